// File: rtl/plru_way_select.sv
// Tree pseudo-LRU victim selector with per-way valid tracking for a 4-way cache.
// Latency: victim registered one cycle after lookup_req; touch/inv update state at the same edge.
// Backpressure: none; accepts a lookup, a touch and an invalidate every cycle.
module plru_way_select #(
  parameter int SET_BITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                lookup_req,
  input  logic [SET_BITS-1:0] lookup_set,
  input  logic                touch_en,
  input  logic [SET_BITS-1:0] touch_set,
  input  logic [1:0]          touch_way,
  input  logic                inv_en,
  input  logic [SET_BITS-1:0] inv_set,
  input  logic [1:0]          inv_way,
  output logic                victim_vld,
  output logic [1:0]          victim_way,
  output logic                victim_full
);

  localparam int NUM_SETS = 1 << SET_BITS;

  // Per-set state: plru[0] root, plru[1] left pair (ways 0/1), plru[2] right pair (ways 2/3).
  logic [2:0] plru_mem  [NUM_SETS];
  logic [3:0] valid_mem [NUM_SETS];

  logic [2:0] rd_plru;
  logic [3:0] rd_valid;
  logic [1:0] sel_way;
  logic       sel_full;

  // Victim choice from the pre-update state: fill invalid ways first, else walk the tree.
  always_comb begin
    rd_plru  = plru_mem[lookup_set];
    rd_valid = valid_mem[lookup_set];
    sel_way  = 2'd0;
    sel_full = 1'b0;
    if (!rd_valid[0]) begin
      sel_way = 2'd0;
    end else if (!rd_valid[1]) begin
      sel_way = 2'd1;
    end else if (!rd_valid[2]) begin
      sel_way = 2'd2;
    end else if (!rd_valid[3]) begin
      sel_way = 2'd3;
    end else begin
      sel_full = 1'b1;
      if (!rd_plru[0]) begin
        sel_way = rd_plru[1] ? 2'd1 : 2'd0;
      end else begin
        sel_way = rd_plru[2] ? 2'd3 : 2'd2;
      end
    end
  end

  // Per-set PLRU and valid state; invalidate is applied after touch so it wins on a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        plru_mem[s]  <= 3'b000;
        valid_mem[s] <= 4'b0000;
      end
    end else begin
      if (touch_en) begin
        plru_mem[touch_set][0] <= ~touch_way[1];
        if (!touch_way[1]) begin
          plru_mem[touch_set][1] <= ~touch_way[0];
        end else begin
          plru_mem[touch_set][2] <= ~touch_way[0];
        end
        valid_mem[touch_set][touch_way] <= 1'b1;
      end
      if (inv_en) begin
        valid_mem[inv_set][inv_way] <= 1'b0;
      end
    end
  end

  // Registered victim: one-cycle valid pulse, way/full hold between lookups.
  always_ff @(posedge clk) begin
    if (rst) begin
      victim_vld  <= 1'b0;
      victim_way  <= 2'd0;
      victim_full <= 1'b0;
    end else begin
      victim_vld <= lookup_req;
      if (lookup_req) begin
        victim_way  <= sel_way;
        victim_full <= sel_full;
      end
    end
  end

endmodule

// File: tb/tb_plru_way_select.sv
// Directed bench for plru_way_select: reset, fill order, tree walk, invalidate, collisions.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Expected values are hand-derived from the PLRU/valid update rules.
module tb_plru_way_select;

  localparam int SET_BITS = 6;

  logic                clk;
  logic                rst;
  logic                lookup_req;
  logic [SET_BITS-1:0] lookup_set;
  logic                touch_en;
  logic [SET_BITS-1:0] touch_set;
  logic [1:0]          touch_way;
  logic                inv_en;
  logic [SET_BITS-1:0] inv_set;
  logic [1:0]          inv_way;
  logic                victim_vld;
  logic [1:0]          victim_way;
  logic                victim_full;

  int pass_cnt = 0;
  int total_cnt = 0;

  plru_way_select #(.SET_BITS(SET_BITS)) dut (
    .clk         (clk),
    .rst         (rst),
    .lookup_req  (lookup_req),
    .lookup_set  (lookup_set),
    .touch_en    (touch_en),
    .touch_set   (touch_set),
    .touch_way   (touch_way),
    .inv_en      (inv_en),
    .inv_set     (inv_set),
    .inv_way     (inv_way),
    .victim_vld  (victim_vld),
    .victim_way  (victim_way),
    .victim_full (victim_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Check the full output triple after a cycle
  task automatic chk_out(input string tag, input logic vld, input logic [1:0] way, input logic full);
    chk({tag, ".vld"},  {1'b0, victim_vld},  {1'b0, vld});
    chk({tag, ".way"},  victim_way,          way);
    chk({tag, ".full"}, {1'b0, victim_full}, {1'b0, full});
  endtask

  task automatic touch(input logic [SET_BITS-1:0] s, input logic [1:0] w);
    touch_en  = 1'b1;
    touch_set = s;
    touch_way = w;
    cyc();
    touch_en  = 1'b0;
  endtask

  task automatic lookup(input logic [SET_BITS-1:0] s);
    lookup_req = 1'b1;
    lookup_set = s;
    cyc();
    lookup_req = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    lookup_req = 1'b0;
    lookup_set = '0;
    touch_en   = 1'b0;
    touch_set  = '0;
    touch_way  = 2'd0;
    inv_en     = 1'b0;
    inv_set    = '0;
    inv_way    = 2'd0;
    cyc();
    cyc();
    chk_out("reset", 1'b0, 2'd0, 1'b0);
    rst = 1'b0;
    cyc();

    // Empty set: lowest invalid way, single-cycle pulse
    lookup(6'd5);
    chk_out("empty_s5", 1'b1, 2'd0, 1'b0);
    cyc();
    chk({"empty_s5_pulse_end"}, {1'b0, victim_vld}, 2'd0);

    // Fill set 5 in order 0..3: plru ends b0=0 b1=0 b2=0 -> way 0
    touch(6'd5, 2'd0);
    touch(6'd5, 2'd1);
    touch(6'd5, 2'd2);
    touch(6'd5, 2'd3);
    lookup(6'd5);
    chk_out("full_s5", 1'b1, 2'd0, 1'b1);

    // Touch way 0: b0=1 b1=1 b2=0 -> way 2
    touch(6'd5, 2'd0);
    lookup(6'd5);
    chk_out("s5_t0", 1'b1, 2'd2, 1'b1);

    // Touch way 3: b0=0 b1=1 b2=0 -> way 1
    touch(6'd5, 2'd3);
    lookup(6'd5);
    chk_out("s5_t3", 1'b1, 2'd1, 1'b1);
    cyc();
    chk_out("hold", 1'b0, 2'd1, 1'b1);

    // Set 9: fill, invalidate way 2 -> refill way 2 first
    touch(6'd9, 2'd0);
    touch(6'd9, 2'd1);
    touch(6'd9, 2'd2);
    touch(6'd9, 2'd3);
    inv_en  = 1'b1;
    inv_set = 6'd9;
    inv_way = 2'd2;
    cyc();
    inv_en = 1'b0;
    lookup(6'd9);
    chk_out("s9_inv2", 1'b1, 2'd2, 1'b0);

    // Touch and invalidate way 2 together: invalidate wins on valid
    touch_en  = 1'b1;
    touch_set = 6'd9;
    touch_way = 2'd2;
    inv_en    = 1'b1;
    inv_set   = 6'd9;
    inv_way   = 2'd2;
    cyc();
    touch_en = 1'b0;
    inv_en   = 1'b0;
    lookup(6'd9);
    chk_out("s9_collide", 1'b1, 2'd2, 1'b0);

    // Refill way 2: b0=0 b1=0 b2=1 -> way 0
    touch(6'd9, 2'd2);
    lookup(6'd9);
    chk_out("s9_refill", 1'b1, 2'd0, 1'b1);

    // Back-to-back lookups on different sets
    lookup_req = 1'b1;
    lookup_set = 6'd5;
    cyc();
    chk_out("b2b_s5", 1'b1, 2'd1, 1'b1);
    lookup_set = 6'd3;
    cyc();
    lookup_req = 1'b0;
    chk_out("b2b_s3", 1'b1, 2'd0, 1'b0);

    // Same-cycle lookup and touch on set 3: victim from pre-update state
    lookup_req = 1'b1;
    lookup_set = 6'd3;
    touch_en   = 1'b1;
    touch_set  = 6'd3;
    touch_way  = 2'd0;
    cyc();
    lookup_req = 1'b0;
    touch_en   = 1'b0;
    chk_out("s3_rbw", 1'b1, 2'd0, 1'b0);
    lookup(6'd3);
    chk_out("s3_after", 1'b1, 2'd1, 1'b0);

    // Touch and invalidate on different sets in one cycle
    touch_en  = 1'b1;
    touch_set = 6'd3;
    touch_way = 2'd1;
    inv_en    = 1'b1;
    inv_set   = 6'd5;
    inv_way   = 2'd3;
    cyc();
    touch_en = 1'b0;
    inv_en   = 1'b0;
    lookup(6'd3);
    chk_out("s3_t1", 1'b1, 2'd2, 1'b0);
    lookup(6'd5);
    chk_out("s5_inv3", 1'b1, 2'd3, 1'b0);

    // Set 12: fill, touch way 0 -> way 2 full, then reset with a lookup in flight
    touch(6'd12, 2'd0);
    touch(6'd12, 2'd1);
    touch(6'd12, 2'd2);
    touch(6'd12, 2'd3);
    touch(6'd12, 2'd0);
    lookup(6'd12);
    chk_out("s12_full", 1'b1, 2'd2, 1'b1);
    rst        = 1'b1;
    lookup_req = 1'b1;
    lookup_set = 6'd12;
    touch_en   = 1'b1;
    touch_set  = 6'd12;
    touch_way  = 2'd1;
    cyc();
    rst        = 1'b0;
    lookup_req = 1'b0;
    touch_en   = 1'b0;
    chk_out("s12_rst", 1'b0, 2'd0, 1'b0);
    lookup(6'd12);
    chk_out("s12_post_rst", 1'b1, 2'd0, 1'b0);
    lookup(6'd9);
    chk_out("s9_post_rst", 1'b1, 2'd0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
